// File: rtl/fetch_inst_queue_if.sv
// Fetch->decode instruction-queue bundle: push side (fs_*), pop side (ds_*), flush and occupancy.
// slave modport is the queue itself; master modport is whoever drives fetch and decode.
// Ports: fs_valid/fs_pc/fs_inst/fs_excp_adef/fs_ready, flush, ds_allow_in/ds_valid/ds_pc/ds_inst/ds_excp_adef, count.
interface fetch_inst_queue_if #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              fs_valid;
  logic [PC_W-1:0]   fs_pc;
  logic [INST_W-1:0] fs_inst;
  logic              fs_excp_adef;
  logic              fs_ready;
  logic              flush;
  logic              ds_allow_in;
  logic              ds_valid;
  logic [PC_W-1:0]   ds_pc;
  logic [INST_W-1:0] ds_inst;
  logic              ds_excp_adef;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  fs_valid, fs_pc, fs_inst, fs_excp_adef, flush, ds_allow_in,
    output fs_ready, ds_valid, ds_pc, ds_inst, ds_excp_adef, count
  );

  modport master (
    output fs_valid, fs_pc, fs_inst, fs_excp_adef, flush, ds_allow_in,
    input  fs_ready, ds_valid, ds_pc, ds_inst, ds_excp_adef, count
  );
endinterface

// File: rtl/fetch_inst_queue.sv
// DEPTH-entry FIFO of {pc, inst, adef} between fetch and decode, with whole-queue flush and occupancy.
// Latency: 1 cycle push->head; 0 cycles when FETCH_QUEUE_BYPASS_EN is defined and the queue is empty.
// Backpressure: fs_ready = not full (no push-through-pop when full); decode pops with ds_allow_in.
// Ports: clk, resetn (async active-low), bus (fetch_inst_queue_if.slave, parameters must match).
// Optional macro FETCH_QUEUE_BYPASS_EN: combinational fs_* -> ds_* path while the queue is empty.
module fetch_inst_queue #(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h1c000000
) (
  input logic               clk,
  input logic               resetn,
  fetch_inst_queue_if.slave bus
);
  // DEPTH is a power of two, so the pointers wrap naturally.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              adef;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             q_vld;
  logic             push;
  logic             pop;
  logic             byp_take;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign q_vld = (count_q != '0);
  assign head  = mem_q[rptr_q];

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp_vld;
  // Empty queue: present the incoming entry directly to decode.
  assign byp_vld  = !q_vld && bus.fs_valid && !bus.flush;
  // Consumed on the spot, so it must not also be written.
  assign byp_take = byp_vld && bus.ds_allow_in;

  always_comb begin
    bus.ds_valid     = q_vld || byp_vld;
    bus.ds_pc        = RESET_PC;
    bus.ds_inst      = '0;
    bus.ds_excp_adef = 1'b0;
    if (q_vld) begin
      bus.ds_pc        = head.pc;
      bus.ds_inst      = head.inst;
      bus.ds_excp_adef = head.adef;
    end else if (byp_vld) begin
      bus.ds_pc        = bus.fs_pc;
      bus.ds_inst      = bus.fs_inst;
      bus.ds_excp_adef = bus.fs_excp_adef;
    end
  end
`else
  assign byp_take = 1'b0;

  always_comb begin
    bus.ds_valid     = q_vld;
    bus.ds_pc        = RESET_PC;
    bus.ds_inst      = '0;
    bus.ds_excp_adef = 1'b0;
    if (q_vld) begin
      bus.ds_pc        = head.pc;
      bus.ds_inst      = head.inst;
      bus.ds_excp_adef = head.adef;
    end
  end
`endif

  // fs_ready deliberately ignores flush; flush simply drops the offered entry.
  assign bus.fs_ready = !full;
  assign bus.count    = count_q;

  assign push = bus.fs_valid && !full && !bus.flush && !byp_take;
  assign pop  = q_vld && bus.ds_allow_in && !bus.flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; validity is carried by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= '{pc: bus.fs_pc, inst: bus.fs_inst, adef: bus.fs_excp_adef};
    end
  end
endmodule

// File: tb/tb_fetch_inst_queue.sv
module tb_fetch_inst_queue;
  localparam int          DEPTH    = 4;
  localparam int          PC_W     = 32;
  localparam int          INST_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fetch_inst_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) bus ();

  fetch_inst_queue #(
    .DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } ent_t;

  ent_t mq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic        cur_v, cur_adef, cur_fl, cur_al;
  logic [31:0] cur_pc, cur_inst;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected outputs from the queue contents and the inputs currently offered.
  task automatic compare_all();
    logic        ev, ead;
    logic [31:0] epc, einst;
    ev = (mq.size() != 0) || (BYP && cur_v && !cur_fl);
    if (mq.size() != 0) begin
      epc = mq[0].pc; einst = mq[0].inst; ead = mq[0].adef;
    end else if (ev) begin
      epc = cur_pc; einst = cur_inst; ead = cur_adef;
    end else begin
      epc = RESET_PC; einst = 32'h0; ead = 1'b0;
    end
    chk("ds_valid", 64'(bus.ds_valid), 64'(ev));
    chk("ds_pc", 64'(bus.ds_pc), 64'(epc));
    chk("ds_inst", 64'(bus.ds_inst), 64'(einst));
    chk("ds_excp_adef", 64'(bus.ds_excp_adef), 64'(ead));
    chk("fs_ready", 64'(bus.fs_ready), 64'(mq.size() != DEPTH));
    chk("count", 64'(bus.count), 64'(mq.size()));
  endtask

  task automatic model_edge();
    bit do_pop, do_push;
    if (cur_fl) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && cur_al;
      do_push = cur_v && (mq.size() != DEPTH) && !(BYP && mq.size() == 0 && cur_al);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{cur_pc, cur_inst, cur_adef});
    end
  endtask

  // Drive inputs (called just after a falling edge), let them settle, compare.
  task automatic settle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic adef, input logic fl, input logic al);
    cur_v = v; cur_pc = pc; cur_inst = inst; cur_adef = adef; cur_fl = fl; cur_al = al;
    bus.fs_valid     = v;
    bus.fs_pc        = pc;
    bus.fs_inst      = inst;
    bus.fs_excp_adef = adef;
    bus.flush        = fl;
    bus.ds_allow_in  = al;
    #1;
    compare_all();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic adef, input logic fl, input logic al);
    settle(v, pc, inst, adef, fl, al);
    finish_cycle();
  endtask

  initial begin
    resetn = 1'b0;
    cur_v = 0; cur_pc = 0; cur_inst = 0; cur_adef = 0; cur_fl = 0; cur_al = 0;
    bus.fs_valid = 0; bus.fs_pc = 0; bus.fs_inst = 0; bus.fs_excp_adef = 0;
    bus.flush = 0; bus.ds_allow_in = 0;
    repeat (2) @(negedge clk);
    // Reset state
    settle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // Fill to DEPTH with decode stalled, then a fifth offer that must be refused.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, RESET_PC + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, RESET_PC + 32'h10, 32'hdead, 1'b0, 1'b0, 1'b0);
    chk("fill_count", 64'(bus.count), 64'(DEPTH));
    chk("fill_ready", 64'(bus.fs_ready), 64'(0));
    chk("fill_head", 64'(bus.ds_pc), 64'(RESET_PC));

    // Drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      settle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("drain_pc", 64'(bus.ds_pc), 64'(RESET_PC + 32'(4 * i)));
      finish_cycle();
    end
    settle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("drained_vld", 64'(bus.ds_valid), 64'(0));
    chk("drained_pc", 64'(bus.ds_pc), 64'(RESET_PC));
    finish_cycle();

    // Streaming at count = 2 across pointer wrap.
    step(1'b1, 32'h1c000100, 32'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1c000104, 32'h2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      settle(1'b1, 32'h1c000108 + 32'(4 * i), 32'(i + 3), 1'b0, 1'b0, 1'b1);
      chk("stream_pc", 64'(bus.ds_pc), 64'(32'h1c000100 + 32'(4 * i)));
      chk("stream_count", 64'(bus.count), 64'(2));
      finish_cycle();
    end

    // Flush priority: bring count to 3, then flush with push and pop offered.
    step(1'b1, 32'h1c000200, 32'h7, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(bus.count), 64'(3));
    step(1'b1, 32'h1c000300, 32'hbad, 1'b0, 1'b1, 1'b1);
    settle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_count", 64'(bus.count), 64'(0));
    chk("flush_vld", 64'(bus.ds_valid), 64'(0));
    finish_cycle();

    // adef travels with its entry.
    step(1'b1, 32'h1c000400, 32'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1c000404, 32'h12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1c000001, 32'h13, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    settle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("adef_tag", 64'(bus.ds_excp_adef), 64'(1));
    chk("adef_pc", 64'(bus.ds_pc), 64'(32'h1c000001));
    finish_cycle();

    // Empty queue, entry offered with decode ready.
    settle(1'b1, 32'h1c000040, 32'h55, 1'b0, 1'b0, 1'b1);
    chk("byp_vld", 64'(bus.ds_valid), 64'(BYP));
    finish_cycle();
    settle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("byp_count", 64'(bus.count), 64'(BYP ? 0 : 1));
    chk("byp_late_vld", 64'(bus.ds_valid), 64'(!BYP));
    finish_cycle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with varying decode pressure.
    for (int i = 0; i < 600; i++) begin
      int al_pct;
      al_pct = (i / 100) % 3 == 0 ? 20 : ((i / 100) % 3 == 1 ? 50 : 85);
      step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 7) == 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 99) < al_pct);
    end

    // Asynchronous reset mid-operation.
    step(1'b1, 32'h1c000500, 32'h21, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1c000504, 32'h22, 1'b0, 1'b0, 1'b0);
    settle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    #1;
    mq.delete();
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_vld", 64'(bus.ds_valid), 64'(0));
    chk("rst_ready", 64'(bus.fs_ready), 64'(1));
    chk("rst_pc", 64'(bus.ds_pc), 64'(RESET_PC));
    @(negedge clk);
    resetn = 1'b1;
    step(1'b1, 32'h1c000600, 32'h31, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Parametrised instruction queue between the fetch stage and the decode stage. It replaces the single IF→ID pipeline register with a DEPTH-entry FIFO of {pc, inst, adef} tuples. This decouples instruction-SRAM return from decode back-pressure, supports whole-queue flush on branch redirect or exception, and reports occupancy. Fetch pushes through a valid/ready handshake; decode pops through valid/allow-in.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- PC_W, 32, PC width
- INST_W, 32, instruction width
- RESET_PC, 32'h1c000000, value presented on ds_pc while the queue is empty

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- fs_valid  in  1  fetch presents a valid entry
- fs_pc  in  PC_W  PC of the entry
- fs_inst  in  INST_W  instruction word (inst_sram_rdata)
- fs_excp_adef  in  1  fetch-address exception tag
- fs_ready  out  1  queue accepts a push this cycle
- flush  in  1  branch-taken cancel or exception flush
- ds_allow_in  in  1  decode accepts the head entry
- ds_valid  out  1  head entry is valid
- ds_pc  out  PC_W  head PC
- ds_inst  out  INST_W  head instruction
- ds_excp_adef  out  1  head adef tag
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH-entry register array. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter runs 0..DEPTH.
- fs_ready = (count != DEPTH). No pass-through push when full, even if a pop happens in the same cycle.
- Push: fs_valid && fs_ready && !flush. Writes entry[wptr], then wptr+1.
- Pop: ds_valid && ds_allow_in && !flush. rptr+1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- ds_valid = (count != 0). Head outputs read combinationally from entry[rptr].
- Empty: ds_pc = RESET_PC, ds_inst = 0, ds_excp_adef = 0.
- flush has priority over push and pop. On the next edge count = 0 and wptr = rptr = 0. The entry offered during the flush cycle is dropped. fs_ready is not gated by flush.
- The adef tag travels with its entry. It is never dropped except by flush.
- Storage contents are not reset. Only pointers and count are reset.

## Timing
- Reset (resetn low, asynchronous): count = 0, pointers = 0, ds_valid = 0, fs_ready = 1, ds_pc = RESET_PC, ds_inst = 0, ds_excp_adef = 0. Release takes effect at the next edge.
- Latency, bypass disabled: an entry pushed at edge N is visible on ds_* after edge N (a 1-cycle register stage, same as the previous IF→ID register).
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- Full with ds_allow_in high: the pop completes at the edge, and fs_ready rises in the following cycle.
- Reset asserted mid-operation: all entries are discarded immediately. No partial pop is reported.
- flush and resetn are independent. resetn dominates.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count == 0 and fs_valid && !flush, ds_* are driven combinationally from fs_* and ds_valid = 1.
  - If ds_allow_in is also high, the entry is consumed without being written and count stays 0 (0-cycle latency).
  - Otherwise the entry is pushed normally.
- FETCH_QUEUE_BYPASS_EN undefined: no combinational path from fs_* to ds_*. Minimum latency is 1 cycle.

## Test plan
- Reset then fill: resetn low, then push pc 0x1c000000..0x1c00000c with ds_allow_in = 0 (DEPTH = 4) → count = 4, fs_ready = 0, ds_pc = 0x1c000000. A fifth offer with fs_valid = 1 is not accepted.
- Drain in order: from full, ds_allow_in = 1 for 4 cycles → ds_pc sequence 0x1c000000, 04, 08, 0c, then ds_valid = 0 and ds_pc = 0x1c000000.
- Wrap-around streaming: 10 consecutive pushes with simultaneous pops at count = 2 → count stays 2 and ds_pc increments by 4 each cycle across pointer wrap.
- Flush priority: count = 3, flush = 1 with fs_valid = 1 and ds_allow_in = 1 → next cycle count = 0 and ds_valid = 0. The flush-cycle entry never appears.
- adef propagation: push pc 0x1c000001 with fs_excp_adef = 1 behind two clean entries → the third pop shows ds_excp_adef = 1 and ds_pc = 0x1c000001.
- Bypass, with FETCH_QUEUE_BYPASS_EN: empty queue, fs_valid = 1, fs_pc = 0x1c000040, ds_allow_in = 1 → in the same cycle ds_valid = 1 and ds_pc = 0x1c000040, and count stays 0. Without the macro, ds_valid rises one cycle later.
